// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, opcode classes, ALU operations and datapath select codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_control_t;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] SRC_A_REG    = 2'b00;
  localparam logic [1:0] SRC_A_PC     = 2'b01;
  localparam logic [1:0] SRC_A_ALUOUT = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation and flag-write decode for data-processing execute states.
// Unsupported commands fall back to ADD and never touch the flags.
module alu_decoder
  import arm_ctrl_pkg::*;
(
  input  logic [4:0]   funct,
  input  logic         alu_op,
  output alu_control_t alu_control,
  output logic [1:0]   flag_w
);

  logic s_bit;
  assign s_bit = funct[0];

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        CMD_ADD: begin alu_control = ALU_ADD; flag_w = {s_bit, s_bit}; end
        CMD_SUB: begin alu_control = ALU_SUB; flag_w = {s_bit, s_bit}; end
        CMD_AND: begin alu_control = ALU_AND; flag_w = {s_bit, 1'b0};  end
        CMD_ORR: begin alu_control = ALU_ORR; flag_w = {s_bit, 1'b0};  end
        default: begin alu_control = ALU_ADD; flag_w = 2'b00;          end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM plus instruction decode producing the
// per-cycle write requests for CondLogic and the datapath mux selects.
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic [1:0] flag_w,
  output logic       next_pc,
  output logic       ir_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_control
);

  state_t state, state_next;

  logic s_reg_w, s_mem_w, s_next_pc, s_ir_write, s_branch, s_alu_op;
  alu_control_t alu_ctl;
  logic [1:0]   dec_flag_w;

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = funct[5] ? EXECI : EXECR;
          OP_BR:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      EXECR,
      EXECI:  state_next = ALUWB;
      // MEMWB, MEMWR, ALUWB, BRANCH and illegal encodings all return to FETCH
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    s_reg_w    = 1'b0;
    s_mem_w    = 1'b0;
    s_next_pc  = 1'b0;
    s_ir_write = 1'b0;
    s_branch   = 1'b0;
    s_alu_op   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRC_A_REG;
    alu_src_b  = SRC_B_REG;
    result_src = RES_ALUOUT;
    case (state)
      FETCH: begin
        s_ir_write = 1'b1;
        s_next_pc  = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
      end
      DECODE: begin
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
      end
      MEMADR: alu_src_b = SRC_B_IMM;
      MEMRD:  adr_src   = 1'b1;
      MEMWB: begin
        result_src = RES_READ;
        s_reg_w    = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1;
        s_mem_w = 1'b1;
      end
      EXECR: s_alu_op = 1'b1;
      EXECI: begin
        alu_src_b = SRC_B_IMM;
        s_alu_op  = 1'b1;
      end
      ALUWB: s_reg_w = 1'b1;
      BRANCH: begin
        alu_src_a  = SRC_A_ALUOUT;
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU;
        s_branch   = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct       (funct[4:0]),
    .alu_op      (s_alu_op),
    .alu_control (alu_ctl),
    .flag_w      (dec_flag_w)
  );

  // Write requests are held off while reset is asserted; state is already FETCH then.
  assign reg_w       = s_reg_w    & ~reset;
  assign mem_w       = s_mem_w    & ~reset;
  assign next_pc     = s_next_pc  & ~reset;
  assign ir_write    = s_ir_write & ~reset;
  assign flag_w      = reset ? 2'b00 : dec_flag_w;
  assign pcs         = ((s_reg_w & (rd == PC_REG)) | s_branch) & ~reset;
  assign alu_control = alu_ctl;
  assign imm_src     = op;
  assign reg_src     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: each issued instruction
// pushes its expected per-cycle control vectors; a negedge monitor pops and compares.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] flag_w;
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] rsrc;
    logic [1:0] aluc;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs, reg_w, mem_w, next_pc, ir_write, adr_src;
  logic [1:0] flag_w, alu_src_a, alu_src_b, result_src, imm_src, reg_src, alu_control;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .pcs         (pcs),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .flag_w      (flag_w),
    .next_pc     (next_pc),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .alu_control (alu_control)
  );

  always #5 clk = ~clk;

  function automatic ctl_t actual();
    ctl_t c;
    c.pcs = pcs; c.reg_w = reg_w; c.mem_w = mem_w; c.flag_w = flag_w;
    c.next_pc = next_pc; c.ir_write = ir_write; c.adr_src = adr_src;
    c.src_a = alu_src_a; c.src_b = alu_src_b; c.res = result_src;
    c.imm = imm_src; c.rsrc = reg_src; c.aluc = alu_control;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected vector per clock while an instruction is in flight.
  always @(negedge clk) begin
    if (!reset && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, 32'(actual()), 32'(e.v));
    end
  end

  function automatic ctl_t base(input logic [1:0] o);
    ctl_t c = '0;
    c.imm  = o;
    c.rsrc = {o == 2'b01, o == 2'b10};
    return c;
  endfunction

  function automatic ctl_t fetch_vec(input logic [1:0] o);
    ctl_t c = base(o);
    c.ir_write = 1'b1; c.next_pc = 1'b1;
    c.src_a = 2'b01; c.src_b = 2'b10; c.res = 2'b10;
    return c;
  endfunction

  // Reference model: expected control vectors for every cycle of one instruction.
  function automatic int expect_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    ctl_t b = base(o);
    ctl_t c;
    logic s = f[0];
    int n = 0;
    sb.push_back('{v: fetch_vec(o), name: "fetch"}); n++;
    c = b; c.src_a = 2'b01; c.src_b = 2'b10; c.res = 2'b10;
    sb.push_back('{v: c, name: "decode"}); n++;
    if (o == 2'b00) begin
      c = b;
      c.src_b = f[5] ? 2'b01 : 2'b00;
      case (f[4:1])
        4'd4:    begin c.aluc = 2'd0; c.flag_w = {s, s};    end
        4'd2:    begin c.aluc = 2'd1; c.flag_w = {s, s};    end
        4'd0:    begin c.aluc = 2'd2; c.flag_w = {s, 1'b0}; end
        4'd12:   begin c.aluc = 2'd3; c.flag_w = {s, 1'b0}; end
        default: begin c.aluc = 2'd0; c.flag_w = 2'b00;     end
      endcase
      sb.push_back('{v: c, name: f[5] ? "exec_imm" : "exec_reg"}); n++;
      c = b; c.reg_w = 1'b1; c.pcs = (r == 4'd15);
      sb.push_back('{v: c, name: "alu_wb"}); n++;
    end else if (o == 2'b01) begin
      c = b; c.src_b = 2'b01;
      sb.push_back('{v: c, name: "mem_adr"}); n++;
      if (s) begin
        c = b; c.adr_src = 1'b1;
        sb.push_back('{v: c, name: "mem_rd"}); n++;
        c = b; c.res = 2'b01; c.reg_w = 1'b1; c.pcs = (r == 4'd15);
        sb.push_back('{v: c, name: "mem_wb"}); n++;
      end else begin
        c = b; c.adr_src = 1'b1; c.mem_w = 1'b1;
        sb.push_back('{v: c, name: "mem_wr"}); n++;
      end
    end else if (o == 2'b10) begin
      c = b; c.src_a = 2'b10; c.src_b = 2'b01; c.res = 2'b10; c.pcs = 1'b1;
      sb.push_back('{v: c, name: "branch"}); n++;
    end
    return n;
  endfunction

  // Called at posedge+1 with the DUT sitting in FETCH.
  task automatic issue(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    int n;
    op = o; funct = f; rd = r;
    n = expect_instr(o, f, r);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] cmds [4];
    logic [3:0] cmd;
    ctl_t rv;
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12};
    reset = 1'b1; op = 2'b00; funct = 6'b000000; rd = 4'd0;
    #1;
    check("reset_state", 32'(actual()), 32'(base(2'b00) | 20'(fetch_vec(2'b00) & ~ctl_t'({1'b1,1'b1,1'b1,2'b11,1'b1,1'b1,13'b0}))));
    @(posedge clk); #1;
    reset = 1'b0;

    // Abandon a register-form data-processing instruction in its execute cycle.
    op = 2'b00; funct = 6'b000101; rd = 4'd15;
    void'(expect_instr(op, funct, rd));
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    sb.delete();
    reset = 1'b1;
    #1;
    rv = fetch_vec(2'b00);
    rv.ir_write = 1'b0; rv.next_pc = 1'b0;
    check("reset_mid_exec", 32'(actual()), 32'(rv));
    @(posedge clk); #1;
    check("reset_hold", 32'(actual()), 32'(rv));
    reset = 1'b0;

    issue(2'b00, 6'b001001, 4'd3);   // ADD imm
    issue(2'b00, 6'b000101, 4'd15);  // SUBS to PC
    issue(2'b00, 6'b000001, 4'd2);   // ANDS
    issue(2'b00, 6'b011000, 4'd4);   // ORR
    issue(2'b00, 6'b000111, 4'd5);   // unsupported cmd with S
    issue(2'b01, 6'b011001, 4'd6);   // LDR
    issue(2'b01, 6'b011001, 4'd15);  // LDR to PC
    issue(2'b01, 6'b011000, 4'd15);  // STR
    issue(2'b10, 6'b100000, 4'd0);   // B
    issue(2'b11, 6'b111111, 4'd15);  // undefined

    for (int i = 0; i < 80; i++) begin
      logic [1:0] o;
      logic [5:0] f;
      logic [3:0] r;
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        cmd = cmds[$urandom_range(0, 3)];
        f[4:1] = cmd;
      end
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      issue(o, f, r);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
